mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port data RAM (14-bit word address, 32-bit data, 1-cycle sync read)
//  between the CPU MEM stage and a DMA/debug loader port. CPU has fixed priority,
//  bounded by a starvation counter that forces a DMA grant. Stalls the pipeline while
//  the RAM is owned by DMA. Sits between MEM stage/loader and the RAM instance.
// PARAMETERS
//  ADDR_W    14  RAM word-address width
//  DATA_W    32  RAM data width
//  LEN_W     8   DMA burst-length field width (beats)
//  MAX_WAIT  15  cycles a pending dma_req may lose to the CPU before a DMA grant is forced
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       reset, asynchronous, active-high
//  cpu_req     in   1       MEM-stage access request (load or store)
//  cpu_we      in   1       1 = store
//  cpu_addr    in   ADDR_W  word address
//  cpu_wdata   in   DATA_W  store data
//  cpu_stall   out  1       request present but not granted this cycle; pipeline holds
//  cpu_rdata   out  DATA_W  load data
//  cpu_rvalid  out  1       cpu_rdata valid (1 cycle after granted load)
//  dma_req     in   1       burst request; dma_we/addr/len sampled at grant
//  dma_we      in   1       1 = write burst
//  dma_addr    in   ADDR_W  burst start address
//  dma_len     in   LEN_W   beats in burst; 0 treated as 1
//  dma_wdata   in   DATA_W  write data, consumed in every dma_wready cycle
//  dma_wready  out  1       write beat issued this cycle
//  dma_rdata   out  DATA_W  read data
//  dma_rvalid  out  1       dma_rdata valid (1 cycle after each read beat)
//  dma_done    out  1       1-cycle pulse, cycle after last beat issued
//  ram_we      out  1       RAM write enable
//  ram_addr    out  ADDR_W  RAM address
//  ram_din     out  DATA_W  RAM write data
//  ram_dout    in   DATA_W  RAM read data (registered, 1-cycle latency)
// BEHAVIOUR
//  - Reset: state IDLE, wait_cnt=0, all outputs 0 (ram_we=0, cpu_stall=0, pulses low).
//  - FSM: IDLE -> DMA_RUN on DMA grant; DMA_RUN -> DMA_END after last beat issued;
//    DMA_END -> IDLE unconditionally (1 cycle).
//  - IDLE grant: cpu_req && !(dma_req && wait_cnt==MAX_WAIT) -> CPU, else dma_req -> DMA.
//    Both requesting, wait_cnt<MAX_WAIT -> CPU wins.
//  - CPU access is combinational pass-through in its grant cycle: ram_addr=cpu_addr,
//    ram_we=cpu_we, ram_din=cpu_wdata; load -> cpu_rvalid=1, cpu_rdata=ram_dout next cycle.
//  - cpu_stall = cpu_req && CPU not granted (DMA grant cycle, DMA_RUN, DMA_END).
//  - wait_cnt: +1 each IDLE cycle dma_req loses to CPU, saturates at MAX_WAIT; cleared on
//    DMA grant and when dma_req low in IDLE.
//  - DMA grant cycle issues beat 0 at dma_addr; one beat per cycle thereafter, address
//    +1 mod 2^ADDR_W (0x3FFF wraps to 0x0000). Burst non-preemptible.
//  - Write burst: dma_wready=1 on each beat, ram_din=dma_wdata same cycle.
//  - Read burst: dma_rvalid=1, dma_rdata=ram_dout one cycle after each beat; last rvalid
//    coincides with dma_done (DMA_END).
//  - dma_req deasserted mid-burst: ignored, burst completes. dma_req held after done: new
//    burst only via IDLE arbitration (CPU first if pending, so no DMA back-to-back
//    starvation of CPU).
//  - rst mid-burst: burst abandoned, no dma_done, no rvalid for in-flight beat.
//  - ram_we=0 in every cycle with no granted write.
// STRUCTURE
//  - Shared package/header mem_arb_pkg: state encoding (IDLE, DMA_RUN, DMA_END),
//    ADDR_W/DATA_W defaults shared with MEM stage and RAM wrapper.
//  - One sub-module: mem_arb_burst_ctr (start-address load, wrap increment, beat
//    down-counter, last-beat flag).
// TESTING
//  1. CPU store 0x1234_5678 @0x0010, then load @0x0010, no DMA -> no stall; cpu_rvalid
//     with 0x1234_5678 1 cycle after load.
//  2. DMA write len=4 @0x3FFE, data 1..4 -> wready 4 cycles, addrs 3FFE,3FFF,0000,0001;
//     dma_done 1 cycle later; CPU reads back 1..4.
//  3. DMA read len=3 while cpu_req held low -> dma_rvalid 3 consecutive cycles, last
//     coincident with dma_done.
//  4. cpu_req and dma_req held continuously -> CPU granted 15 cycles, then DMA granted
//     (cpu_stall high for burst+1), CPU regains on return to IDLE.
//  5. dma_len=0 -> exactly 1 beat, dma_done next cycle.
//  6. rst asserted in 2nd beat of len=8 write -> outputs 0 immediately, no dma_done;
//     after release CPU access ungated.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-RAM port arbiter: default RAM geometry
// (also used by the MEM stage and the RAM wrapper) and the arbiter state encoding.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DMA_RUN = 2'd1,
        DMA_END = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_burst_ctr.sv
// DMA burst address/beat counter. Loading happens in the grant cycle, which
// itself issues beat 0 at start_addr, so the counter holds the address and
// the remaining beat count for the beats that follow.
module mem_arb_burst_ctr
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              first_last
);

    logic [LEN_W-1:0] remain;

    // A length of 0 or 1 means the grant-cycle beat is the whole burst.
    assign first_last = (len <= LEN_W'(1));
    // The beat issued in the current run cycle is the final one.
    assign last       = (remain == LEN_W'(1));

    // Beats still to issue after the grant-cycle beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain <= '0;
        end else if (load) begin
            remain <= (len == '0) ? '0 : len - LEN_W'(1);
        end else if (adv) begin
            remain <= remain - LEN_W'(1);
        end
    end

    // Next beat address; natural overflow gives the wrap from top of RAM to 0.
    always_ff @(posedge clk) begin
        if (load) begin
            addr <= start_addr + ADDR_W'(1);
        end else if (adv) begin
            addr <= addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data RAM arbiter between the CPU MEM stage and the DMA/debug
// loader. CPU has fixed priority; a starvation counter forces a DMA grant
// after MAX_WAIT lost cycles. DMA bursts are non-preemptible and stall the CPU.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LEN_W    = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [LEN_W-1:0]  dma_len,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_wready,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              dma_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    arb_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              burst_we;
    logic              cpu_rd_vld_p1;
    logic              dma_rd_vld_p1;

    logic              wait_full;
    logic              cpu_gnt;
    logic              dma_gnt;
    logic              dma_beat;
    logic              beat_we;
    logic [ADDR_W-1:0] beat_addr;

    logic [ADDR_W-1:0] ctr_addr;
    logic              ctr_last;
    logic              ctr_first_last;

    mem_arb_burst_ctr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_burst_ctr (
        .clk        (clk),
        .rst        (rst),
        .load       (dma_gnt),
        .adv        (state == DMA_RUN),
        .start_addr (dma_addr),
        .len        (dma_len),
        .addr       (ctr_addr),
        .last       (ctr_last),
        .first_last (ctr_first_last)
    );

    // Arbitration and beat selection; grants are suppressed while rst is held
    // so every output is quiet during reset.
    always_comb begin
        wait_full = (wait_cnt == WAIT_W'(MAX_WAIT));
        cpu_gnt   = (state == IDLE) && !rst && cpu_req && !(dma_req && wait_full);
        dma_gnt   = (state == IDLE) && !rst && !cpu_gnt && dma_req;
        dma_beat  = dma_gnt || (state == DMA_RUN);
        beat_we   = dma_gnt ? dma_we : burst_we;
        beat_addr = dma_gnt ? dma_addr : ctr_addr;
    end

    // RAM port mux and handshake outputs.
    always_comb begin
        ram_we     = cpu_gnt ? cpu_we : (dma_beat && beat_we);
        ram_addr   = cpu_gnt ? cpu_addr : (dma_beat ? beat_addr : '0);
        ram_din    = cpu_gnt ? cpu_wdata : (dma_beat ? dma_wdata : '0);
        dma_wready = dma_beat && beat_we;
        cpu_stall  = cpu_req && !cpu_gnt && !rst;
        dma_done   = (state == DMA_END);
        cpu_rvalid = cpu_rd_vld_p1;
        cpu_rdata  = cpu_rd_vld_p1 ? ram_dout : '0;
        dma_rvalid = dma_rd_vld_p1;
        dma_rdata  = dma_rd_vld_p1 ? ram_dout : '0;
    end

    // Ownership FSM, starvation counter and read-valid tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            burst_we      <= 1'b0;
            cpu_rd_vld_p1 <= 1'b0;
            dma_rd_vld_p1 <= 1'b0;
        end else begin
            // ---- stage p0 -> p1: RAM read data returns one cycle after the beat
            cpu_rd_vld_p1 <= cpu_gnt && !cpu_we;
            dma_rd_vld_p1 <= dma_beat && !beat_we;
            case (state)
                IDLE: begin
                    if (dma_gnt) begin
                        state    <= ctr_first_last ? DMA_END : DMA_RUN;
                        burst_we <= dma_we;
                        wait_cnt <= '0;
                    end else if (cpu_gnt && dma_req) begin
                        if (!wait_full) begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                DMA_RUN: begin
                    if (ctr_last) begin
                        state <= DMA_END;
                    end
                end
                DMA_END: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a RAM model, a transaction-level reference
// (beat counter + shadow memory), a table of CPU vectors, directed burst
// sequences and a randomized run.
module tb_mem_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;
    logic [LW-1:0] dma_len;
    logic          cpu_stall, cpu_rvalid, dma_wready, dma_rvalid, dma_done, ram_we;
    logic [DW-1:0] cpu_rdata, dma_rdata, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_wdata(dma_wdata), .dma_wready(dma_wready), .dma_rdata(dma_rdata),
        .dma_rvalid(dma_rvalid), .dma_done(dma_done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Background content of never-written RAM words.
    function automatic logic [31:0] init_pat(input logic [13:0] a);
        return {a, 18'h0} ^ 32'hA5A5_0000 ^ {18'h0, a};
    endfunction

    // RAM model: synchronous read-first, 1-cycle latency.
    bit [31:0] mem    [0:16383];
    bit        mem_wr [0:16383];
    always @(posedge clk) begin
        ram_dout <= mem_wr[ram_addr] ? mem[ram_addr] : init_pat(ram_addr);
        if (ram_we) begin
            mem[ram_addr]    <= ram_din;
            mem_wr[ram_addr] <= 1'b1;
        end
    end

    // Reference model state.
    bit [31:0]   ref_mem [0:16383];
    bit          ref_wr  [0:16383];
    int          m_beats, m_wait, n_beats, n_wait;
    bit          m_end, m_dwe, m_crv, m_drv, n_end, n_dwe, n_crv, n_drv, n_wr;
    logic [13:0] m_daddr, n_daddr, n_wa;
    logic [31:0] m_crd, m_drd, n_crd, n_drd, n_wd;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    function automatic logic [31:0] ref_rd(input logic [13:0] a);
        return ref_wr[a] ? ref_mem[a] : init_pat(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // Predict this cycle's outputs from the model and compare; compute next state.
    task automatic model_eval();
        int          beats;
        logic [13:0] daddr;
        bit          dwe, busy, cg, dg, beat;
        if (rst) begin
            chk("m_rst_stall", cpu_stall, 0);
            chk("m_rst_we", ram_we, 0);
            chk("m_rst_wready", dma_wready, 0);
            chk("m_rst_done", dma_done, 0);
            chk("m_rst_crv", cpu_rvalid, 0);
            chk("m_rst_drv", dma_rvalid, 0);
            chk("m_rst_crd", cpu_rdata, 0);
            chk("m_rst_drd", dma_rdata, 0);
            return;
        end
        busy  = (m_beats > 0) || m_end;
        cg    = !busy && cpu_req && !(dma_req && m_wait == MW);
        dg    = !busy && !cg && dma_req;
        beats = m_beats;
        daddr = m_daddr;
        dwe   = m_dwe;
        if (dg) begin
            beats = (dma_len == 0) ? 1 : int'(dma_len);
            daddr = dma_addr;
            dwe   = dma_we;
        end
        beat = (beats > 0);
        chk("m_stall", cpu_stall, cpu_req && !cg);
        chk("m_done", dma_done, m_end);
        chk("m_crv", cpu_rvalid, m_crv);
        chk("m_crd", cpu_rdata, m_crv ? m_crd : 32'h0);
        chk("m_drv", dma_rvalid, m_drv);
        chk("m_drd", dma_rdata, m_drv ? m_drd : 32'h0);
        if (cg) begin
            chk("m_cpu_we", ram_we, cpu_we);
            chk("m_cpu_addr", ram_addr, cpu_addr);
            chk("m_cpu_wready", dma_wready, 0);
            if (cpu_we) chk("m_cpu_din", ram_din, cpu_wdata);
        end else if (beat) begin
            chk("m_dma_we", ram_we, dwe);
            chk("m_dma_addr", ram_addr, daddr);
            chk("m_dma_wready", dma_wready, dwe);
            if (dwe) chk("m_dma_din", ram_din, dma_wdata);
        end else begin
            chk("m_idle_we", ram_we, 0);
            chk("m_idle_wready", dma_wready, 0);
        end
        n_crv = cg && !cpu_we;
        n_crd = ref_rd(cpu_addr);
        n_drv = beat && !dwe;
        n_drd = ref_rd(daddr);
        n_wr  = (cg && cpu_we) || (beat && dwe);
        n_wa  = cg ? cpu_addr : daddr;
        n_wd  = cg ? cpu_wdata : dma_wdata;
        if (beat) begin
            beats = beats - 1;
            daddr = daddr + 14'd1;
        end
        n_beats = beats;
        n_daddr = daddr;
        n_dwe   = dwe;
        n_end   = beat && (beats == 0);
        if (busy)                n_wait = m_wait;
        else if (dma_req && cg)  n_wait = (m_wait < MW) ? m_wait + 1 : MW;
        else                     n_wait = 0;
    endtask

    task automatic model_commit();
        if (rst) begin
            m_beats = 0; m_wait = 0; m_end = 0; m_dwe = 0; m_crv = 0; m_drv = 0;
            m_daddr = '0; m_crd = '0; m_drd = '0;
        end else begin
            m_beats = n_beats; m_wait = n_wait; m_end = n_end; m_dwe = n_dwe;
            m_crv = n_crv; m_drv = n_drv; m_daddr = n_daddr; m_crd = n_crd; m_drd = n_drd;
            if (n_wr) begin
                ref_mem[n_wa] = n_wd;
                ref_wr[n_wa]  = 1'b1;
            end
        end
    endtask

    task automatic tick_a();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick_b();
        @(posedge clk);
        model_commit();
        cyc++;
        #1;
    endtask

    task automatic set_dma(input bit req, input bit we, input logic [13:0] a, input logic [7:0] len);
        dma_req = req; dma_we = we; dma_addr = a; dma_len = len;
    endtask

    typedef struct {
        bit          creq;
        bit          cwe;
        logic [13:0] caddr;
        logic [31:0] cwd;
        bit          dreq;
        bit          e_stall;
        bit          e_we;
        bit          chk_addr;
        logic [13:0] e_addr;
        bit          e_rv;
        logic [31:0] e_rd;
    } vec_t;

    vec_t        tbl [8];
    logic [13:0] exp_a [4];
    bit          dma_hold;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        set_dma(1'b1, 1'b0, 14'h0, 8'd1);
        dma_wdata = '0;
        model_commit();

        // Reset: every output low even with both requesters active.
        for (int i = 0; i < 2; i++) begin
            tick_a();
            chk("rst_stall", cpu_stall, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_done", dma_done, 0);
            tick_b();
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        rst = 1'b0;

        // CPU vector table.
        tbl[0] = '{1'b1, 1'b1, 14'h0010, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0010, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 14'h0010, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 14'h0010, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 14'h0000, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 1'b1, 32'h1234_5678};
        tbl[3] = '{1'b1, 1'b1, 14'h0020, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b1, 14'h0020, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 1'b0, 14'h0020, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 14'h0020, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 1'b0, 14'h0000, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 1'b1, 32'hDEAD_BEEF};
        tbl[6] = '{1'b1, 1'b0, 14'h3FFF, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 14'h3FFF, 1'b0, 32'h0};
        tbl[7] = '{1'b0, 1'b0, 14'h0000, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 1'b1, init_pat(14'h3FFF)};
        for (int i = 0; i < 8; i++) begin
            cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe;
            cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
            set_dma(tbl[i].dreq, 1'b0, 14'h0, 8'd1);
            tick_a();
            chk("tbl_stall", cpu_stall, tbl[i].e_stall);
            chk("tbl_we", ram_we, tbl[i].e_we);
            if (tbl[i].chk_addr) chk("tbl_addr", ram_addr, tbl[i].e_addr);
            chk("tbl_rvalid", cpu_rvalid, tbl[i].e_rv);
            chk("tbl_rdata", cpu_rdata, tbl[i].e_rd);
            tick_b();
        end

        // DMA write burst wrapping the top of RAM, then CPU readback.
        cpu_req = 1'b0;
        exp_a = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        set_dma(1'b1, 1'b1, 14'h3FFE, 8'd4);
        for (int k = 0; k < 4; k++) begin
            dma_wdata = 32'(k + 1);
            if (k > 0) dma_req = 1'b0;
            tick_a();
            chk("t2_wready", dma_wready, 1);
            chk("t2_addr", ram_addr, exp_a[k]);
            chk("t2_din", ram_din, 32'(k + 1));
            chk("t2_done_early", dma_done, 0);
            tick_b();
        end
        tick_a();
        chk("t2_done", dma_done, 1);
        chk("t2_wready_end", dma_wready, 0);
        tick_b();
        tick_a();
        chk("t2_done_pulse", dma_done, 0);
        tick_b();
        for (int k = 0; k < 5; k++) begin
            cpu_req = (k < 4); cpu_we = 1'b0;
            cpu_addr = exp_a[k % 4];
            tick_a();
            if (k > 0) begin
                chk("t2_rb_valid", cpu_rvalid, 1);
                chk("t2_rb_data", cpu_rdata, 32'(k));
            end
            tick_b();
        end

        // DMA read burst with the CPU idle.
        cpu_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            set_dma(c == 0, 1'b0, 14'h0010, 8'd3);
            tick_a();
            chk("t3_rvalid", dma_rvalid, (c >= 1) && (c <= 3));
            chk("t3_done", dma_done, c == 3);
            if (c == 1) chk("t3_rdata", dma_rdata, 32'h1234_5678);
            tick_b();
        end

        // Both requesting continuously: starvation bound forces a DMA grant.
        for (int c = 0; c < 20; c++) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'(c);
            set_dma(1'b1, 1'b0, 14'h0040, 8'd2);
            tick_a();
            chk("t4_stall", cpu_stall, (c >= 15) && (c <= 17));
            if (c == 15) chk("t4_dma_addr", ram_addr, 14'h0040);
            if (c == 18) chk("t4_cpu_back", ram_addr, 14'd18);
            tick_b();
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick_a();
        tick_b();

        // Zero-length burst behaves as a single beat.
        dma_wdata = 32'hCAFE_F00D;
        for (int c = 0; c < 3; c++) begin
            set_dma(c == 0, 1'b1, 14'h0100, 8'd0);
            tick_a();
            chk("t5_wready", dma_wready, c == 0);
            chk("t5_done", dma_done, c == 1);
            tick_b();
        end

        // Reset during the second beat of an 8-beat write.
        set_dma(1'b1, 1'b1, 14'h0200, 8'd8);
        dma_wdata = 32'hA0;
        tick_a();
        chk("t6_beat0", dma_wready, 1);
        tick_b();
        dma_req = 1'b0; dma_wdata = 32'hA1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0200;
        tick_a();
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_we", ram_we, 0);
        chk("t6_rst_wready", dma_wready, 0);
        chk("t6_rst_stall", cpu_stall, 0);
        chk("t6_rst_done", dma_done, 0);
        tick_b();
        tick_a();
        tick_b();
        rst = 1'b0;
        tick_a();
        chk("t6_cpu_stall", cpu_stall, 0);
        chk("t6_cpu_addr", ram_addr, 14'h0200);
        chk("t6_no_done", dma_done, 0);
        tick_b();
        cpu_req = 1'b0;
        tick_a();
        chk("t6_rd_valid", cpu_rvalid, 1);
        chk("t6_rd_data", cpu_rdata, 32'hA0);
        chk("t6_no_done2", dma_done, 0);
        chk("t6_no_drv", dma_rvalid, 0);
        tick_b();

        // Randomized traffic against the reference model.
        dma_hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (rst) rst = 1'b0;
            else     rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) dma_hold = !dma_hold;
            cpu_req   = ($urandom_range(0, 9) < 8);
            cpu_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = 14'($urandom_range(0, 31));
            cpu_wdata = $urandom;
            dma_req   = dma_hold;
            dma_we    = $urandom_range(0, 1) == 1;
            dma_addr  = ($urandom_range(0, 2) == 0) ? 14'(16380 + $urandom_range(0, 3))
                                                    : 14'($urandom_range(0, 31));
            dma_len   = 8'($urandom_range(0, 5));
            dma_wdata = $urandom;
            tick_a();
            tick_b();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
